// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master wishbone arbiter: grant state
// encoding, default bus widths and the data pattern returned on a
// watchdog termination.
package wb_arbiter_pkg;

    // Bus widths shared with the SPI command builder and the bus dispatcher.
    localparam int WB_ADDR_W = 7;
    localparam int WB_DATA_W = 32;

    // A watchdog-terminated transfer returns every data bit set.
    localparam logic                 TIMEOUT_FILL = 1'b1;
    localparam logic [WB_DATA_W-1:0] TIMEOUT_DATA = {WB_DATA_W{TIMEOUT_FILL}};

    // Width of the terminated-transfer counter (saturates at its maximum).
    localparam int TCOUNT_W = 8;

    // Grant state. Encoding 2'd3 is unused and recovers to idle.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

    // Watchdog counter width: must hold values up to TIMEOUT-1. A disabled
    // watchdog (TIMEOUT=0) still gets one bit so no zero-width vector exists.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog for the granted master. Counts strobe cycles that go
// unacknowledged, flags the cycle on which the limit is reached, and keeps
// a saturating tally of how many transfers it has terminated.
// TIMEOUT must be in 0..65535; 0 disables termination entirely.
module wb_watchdog
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,   // no grant held, or grant being released
    input  logic                i_active,  // granted master has cyc and stb high
    input  logic                i_ack,     // slave acknowledge this cycle
    output logic                o_expire,  // terminate the pending transfer now
    output logic [TCOUNT_W-1:0] o_timeout_count
);

    localparam int WDOG_W = wdog_width(TIMEOUT);

    logic [WDOG_W-1:0]   r_wdog;
    logic [TCOUNT_W-1:0] r_count;
    logic                w_at_limit;
    logic                w_expire;
    logic                w_restart;

    // The limit is reached on the TIMEOUT-th consecutive unacknowledged
    // strobe cycle; a real ack on that same cycle takes priority.
    assign w_at_limit = (TIMEOUT != 0) && (r_wdog == WDOG_W'(TIMEOUT - 1));
    assign w_expire   = i_active && !i_ack && !i_clear && w_at_limit;
    assign w_restart  = (TIMEOUT == 0) || i_clear || i_ack || !i_active || w_expire;

    assign o_expire        = w_expire;
    assign o_timeout_count = r_count;

    // Stall counter and saturating termination tally.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog  <= '0;
            r_count <= '0;
        end else begin
            if (w_restart) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_expire && (r_count != {TCOUNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave wishbone arbiter. Master 0 is the SPI command
// builder, master 1 a secondary command source; the slave side feeds the
// bus dispatcher. Grants alternate on contention and are held for an entire
// cyc cycle. A watchdog terminates strobes the slave never acknowledges.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_wb_cyc_i,
    input  logic                m0_wb_stb_i,
    input  logic                m0_wb_we_i,
    input  logic [ADDR_W-1:0]   m0_wb_adr_i,
    input  logic [DATA_W-1:0]   m0_wb_dat_i,
    output logic [DATA_W-1:0]   m0_wb_dat_o,
    output logic                m0_wb_ack_o,

    input  logic                m1_wb_cyc_i,
    input  logic                m1_wb_stb_i,
    input  logic                m1_wb_we_i,
    input  logic [ADDR_W-1:0]   m1_wb_adr_i,
    input  logic [DATA_W-1:0]   m1_wb_dat_i,
    output logic [DATA_W-1:0]   m1_wb_dat_o,
    output logic                m1_wb_ack_o,

    output logic                s_wb_cyc_o,
    output logic                s_wb_stb_o,
    output logic                s_wb_we_o,
    output logic [ADDR_W-1:0]   s_wb_adr_o,
    output logic [DATA_W-1:0]   s_wb_dat_o,
    input  logic [DATA_W-1:0]   s_wb_dat_i,
    input  logic                s_wb_ack_i,

    output logic                timeout_o,
    output logic [TCOUNT_W-1:0] timeout_count
);

    arb_state_t        r_state;
    logic              r_last_grant;   // index of the master served most recently

    logic              w_grant0;
    logic              w_grant1;
    logic              w_granted;

    // Signals of whichever master currently holds the grant (all 0 in idle).
    logic              w_g_cyc;
    logic              w_g_stb;
    logic              w_g_we;
    logic [ADDR_W-1:0] w_g_adr;
    logic [DATA_W-1:0] w_g_dat;

    logic              w_release;
    logic              w_wd_clear;
    logic              w_wd_active;
    logic              w_expire;
    logic              w_fwd_ack;
    logic              w_m_ack;
    logic [DATA_W-1:0] w_m_dat;

    assign w_grant0  = (r_state == ARB_GRANT0);
    assign w_grant1  = (r_state == ARB_GRANT1);
    assign w_granted = w_grant0 || w_grant1;

    // Select the granted master's request signals.
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value held and no latch is inferred.
    always_comb begin
        w_g_cyc = 1'b0;
        w_g_stb = 1'b0;
        w_g_we  = 1'b0;
        w_g_adr = '0;
        w_g_dat = '0;
        if (w_grant0) begin
            w_g_cyc = m0_wb_cyc_i;
            w_g_stb = m0_wb_stb_i;
            w_g_we  = m0_wb_we_i;
            w_g_adr = m0_wb_adr_i;
            w_g_dat = m0_wb_dat_i;
        end else if (w_grant1) begin
            w_g_cyc = m1_wb_cyc_i;
            w_g_stb = m1_wb_stb_i;
            w_g_we  = m1_wb_we_i;
            w_g_adr = m1_wb_adr_i;
            w_g_dat = m1_wb_dat_i;
        end
    end

    // Dropping cyc ends the grant, even with a strobe still pending; that
    // is an ordinary release, so the watchdog restarts instead of firing.
    assign w_release   = w_granted && !w_g_cyc;
    assign w_wd_clear  = !w_granted || w_release;
    assign w_wd_active = w_g_cyc && w_g_stb;

    // Slave acks only reach a master while it is actually strobing.
    assign w_fwd_ack = w_wd_active && s_wb_ack_i;
    assign w_m_ack   = w_fwd_ack || w_expire;
    assign w_m_dat   = w_expire ? {DATA_W{TIMEOUT_FILL}} : s_wb_dat_i;

    wb_watchdog #(
        .TIMEOUT         (TIMEOUT)
    ) u_watchdog (
        .clk             (clk),
        .rst             (rst),
        .i_clear         (w_wd_clear),
        .i_active        (w_wd_active),
        .i_ack           (s_wb_ack_i),
        .o_expire        (w_expire),
        .o_timeout_count (timeout_count)
    );

    // Drive slave-side and master-side outputs from the current grant.
    always_comb begin
        s_wb_cyc_o  = w_g_cyc;
        s_wb_stb_o  = w_g_stb && !w_expire;
        s_wb_we_o   = w_g_we;
        s_wb_adr_o  = w_g_adr;
        s_wb_dat_o  = w_g_dat;
        m0_wb_ack_o = 1'b0;
        m0_wb_dat_o = '0;
        m1_wb_ack_o = 1'b0;
        m1_wb_dat_o = '0;
        timeout_o   = w_expire;
        if (w_grant0) begin
            m0_wb_ack_o = w_m_ack;
            m0_wb_dat_o = w_m_dat;
        end else if (w_grant1) begin
            m1_wb_ack_o = w_m_ack;
            m1_wb_dat_o = w_m_dat;
        end
    end

    // Grant FSM: round-robin on ties, grant held until the owner drops cyc,
    // and a waiting master is handed the bus directly with no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                        r_state <= r_last_grant ? ARB_GRANT0 : ARB_GRANT1;
                    end else if (m0_wb_cyc_i) begin
                        r_state <= ARB_GRANT0;
                    end else if (m1_wb_cyc_i) begin
                        r_state <= ARB_GRANT1;
                    end
                end
                ARB_GRANT0: begin
                    if (!m0_wb_cyc_i) begin
                        r_last_grant <= 1'b0;
                        r_state      <= m1_wb_cyc_i ? ARB_GRANT1 : ARB_IDLE;
                    end
                end
                ARB_GRANT1: begin
                    if (!m1_wb_cyc_i) begin
                        r_last_grant <= 1'b1;
                        r_state      <= m0_wb_cyc_i ? ARB_GRANT0 : ARB_IDLE;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
